// File: rtl/never8_pkg.sv
// Shared definitions for the Never8 controller: widths, opcodes, instruction
// field positions and the sequencer state encoding.
package never8_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int SEL_W  = 5;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_MOV  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd5;
    localparam logic [2:0] OP_BRZ  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Bit positions inside the 16-bit instruction word {hi, lo}
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 4;
    localparam int RS_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_DECODE,
        ST_RD_A,
        ST_LAT_A,
        ST_RD_B,
        ST_LAT_B,
        ST_WRITE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit add/subtract unit; c is carry for add and borrow for sub.
module alu8
    import never8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              z
);

    logic [DATA_W:0] w_sum;

    // The ninth bit of a zero-extended subtraction is set exactly when a < b.
    always_comb begin
        if (sub) begin
            w_sum = {1'b0, a} - {1'b0, b};
        end else begin
            w_sum = {1'b0, a} + {1'b0, b};
        end
    end

    assign y = w_sum[DATA_W-1:0];
    assign c = w_sum[DATA_W];
    assign z = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/regbank.sv
// 32 x 8 register file with a registered read port; r0 always reads zero.
module regbank
    import never8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_reg,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] r_regs [32];

    // Contents survive reset so an aborted instruction leaves state visible.
    always_ff @(posedge clk) begin
        if (write_reg && (sel != '0)) begin
            r_regs[sel] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= (sel == '0) ? '0 : r_regs[sel];
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Never8 fetch/decode/execute controller: two-byte fetch, regbank sequencing
// through a single select port, internal ALU, PC and Z/C flags.
module cpu_sequencer
    import never8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [SEL_W-1:0]  rb_sel,
    output logic [DATA_W-1:0] rb_data_in,
    output logic              rb_write_reg,
    input  logic [DATA_W-1:0] rb_data_out,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_z;
    logic              r_c;

    logic [15:0]       w_ir;
    logic [2:0]        w_op;
    logic [SEL_W-1:0]  w_rd;
    logic [SEL_W-1:0]  w_rs;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_c;
    logic              w_alu_z;
    logic              w_is_arith;
    logic [DATA_W-1:0] w_result;

    assign w_ir       = {r_hi, r_lo};
    assign w_op       = w_ir[OP_MSB:OP_LSB];
    assign w_rd       = w_ir[RD_MSB:RD_LSB];
    assign w_rs       = w_ir[RS_MSB:RS_LSB];
    assign w_imm      = w_ir[IMM_MSB:IMM_LSB];
    assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

    alu8 u_alu (
        .a   (r_a),
        .b   (r_b),
        .sub (w_op == OP_SUB),
        .y   (w_alu_y),
        .c   (w_alu_c),
        .z   (w_alu_z)
    );

    always_comb begin
        case (w_op)
            OP_LDI:  w_result = w_imm;
            OP_MOV:  w_result = r_b;
            default: w_result = w_alu_y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode straight from state so reset kills a pending write at once.
    always_comb begin
        w_next       = r_state;
        mem_rd       = 1'b0;
        rb_sel       = '0;
        rb_data_in   = '0;
        rb_write_reg = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH_HI;
            ST_FETCH_HI: begin
                mem_rd = 1'b1;
                if (mem_ready) w_next = ST_FETCH_LO;
            end
            ST_FETCH_LO: begin
                mem_rd = 1'b1;
                if (mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_LDI:         w_next = ST_WRITE;
                    OP_MOV:         w_next = ST_RD_B;
                    OP_ADD, OP_SUB: w_next = ST_RD_A;
                    OP_HALT:        w_next = ST_HALT;
                    default:        w_next = ST_FETCH_HI;
                endcase
            end
            ST_RD_A: begin
                rb_sel = w_rd;
                w_next = ST_LAT_A;
            end
            ST_LAT_A: begin
                rb_sel = w_rd;
                w_next = ST_RD_B;
            end
            ST_RD_B: begin
                rb_sel = w_rs;
                w_next = ST_LAT_B;
            end
            ST_LAT_B: begin
                rb_sel = w_rs;
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                rb_sel       = w_rd;
                rb_data_in   = w_result;
                rb_write_reg = 1'b1;
                w_next       = ST_FETCH_HI;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            r_hi <= '0;
            r_lo <= '0;
            r_a  <= '0;
            r_b  <= '0;
            r_z  <= 1'b0;
            r_c  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        r_hi <= mem_data;
                        r_pc <= r_pc + 8'd1;
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ready) begin
                        r_lo <= mem_data;
                        r_pc <= r_pc + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if ((w_op == OP_JMP) || ((w_op == OP_BRZ) && r_z)) begin
                        r_pc <= w_imm;
                    end
                end
                ST_LAT_A: r_a <= rb_data_out;
                ST_LAT_B: r_b <= rb_data_out;
                ST_WRITE: begin
                    r_z <= w_is_arith ? w_alu_z : (w_result == '0);
                    if (w_is_arith) r_c <= w_alu_c;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign flag_z   = r_z;
    assign flag_c   = r_c;
    assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: an instruction-level model predicts fetches, register
// writes and halt timing; a monitor compares them as the sequencer runs.
module tb_cpu_sequencer;
    import never8_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic [4:0] rb_sel;
    logic [7:0] rb_data_in;
    logic       rb_write_reg;
    logic [7:0] rb_data_out;
    logic [7:0] pc;
    logic       flag_z;
    logic       flag_c;
    logic       halted;

    typedef struct {
        logic [4:0] sel;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] pc;
        logic       z;
        logic       c;
    } fe_t;

    logic [7:0] mem [256];
    logic [7:0] mRegs [32];
    wr_t        expWr[$];
    fe_t        expFe[$];
    int         expCycles;
    bit         expHalt;
    int         nChecks = 0;
    int         nFails = 0;
    int         readyMode = 0;
    int         cyc;
    bit         tracking = 1'b0;
    int         byteCnt = 0;
    int         stallCnt = 0;
    int         haltCycle = -1;

    always #5 clk = ~clk;

    // Garbage on the bus when not ready catches early captures.
    assign mem_data = mem_ready ? mem[mem_addr] : (mem_addr ^ 8'hA5);

    cpu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rb_sel       (rb_sel),
        .rb_data_in   (rb_data_in),
        .rb_write_reg (rb_write_reg),
        .rb_data_out  (rb_data_out),
        .pc           (pc),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .halted       (halted)
    );

    regbank u_rb (
        .clk       (clk),
        .rst       (rst),
        .sel       (rb_sel),
        .data_in   (rb_data_in),
        .write_reg (rb_write_reg),
        .data_out  (rb_data_out)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                2:       mem_ready = !(cyc >= 2 && cyc <= 4);
                default: mem_ready = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted hi byte and every register write pops an entry.
    always @(negedge clk) begin
        wr_t w;
        fe_t f;
        if (!rst && tracking) begin
            if (rb_write_reg) begin
                if (expWr.size() == 0) begin
                    checkOutput("unexpected write", 16'd1, 16'd0);
                end else begin
                    w = expWr.pop_front();
                    checkOutput("write sel", {11'd0, rb_sel}, {11'd0, w.sel});
                    checkOutput("write data", {8'd0, rb_data_in}, {8'd0, w.data});
                end
            end
            if (mem_rd && !mem_ready) stallCnt++;
            if (mem_rd && mem_ready) begin
                if (byteCnt % 2 == 0) begin
                    if (expFe.size() == 0) begin
                        checkOutput("unexpected fetch", 16'd1, 16'd0);
                    end else begin
                        f = expFe.pop_front();
                        checkOutput("fetch pc", {8'd0, mem_addr}, {8'd0, f.pc});
                        checkOutput("flag z", {15'd0, flag_z}, {15'd0, f.z});
                        checkOutput("flag c", {15'd0, flag_c}, {15'd0, f.c});
                    end
                end
                byteCnt++;
            end
            if (halted && haltCycle < 0) haltCycle = cyc - 1;
        end
    end

    // Instruction-level reference: runs the program from pc 0 with clear flags.
    task automatic runModel(input int maxI);
        logic [7:0] p, hi, lo, a, b, y;
        logic [4:0] rd, rs;
        logic       z, c;
        int         s;
        p = 8'd0; z = 1'b0; c = 1'b0;
        expCycles = 0;
        expHalt = 1'b0;
        for (int k = 0; k < maxI; k++) begin
            hi = mem[p];
            lo = mem[p + 8'd1];
            expFe.push_back('{pc: p, z: z, c: c});
            p  = p + 8'd2;
            rd = hi[4:0];
            rs = lo[4:0];
            y  = 8'd0;
            case (hi[7:5])
                3'd1: begin y = lo; z = (y == 0); expCycles += 4; end
                3'd2: begin y = mRegs[rs]; z = (y == 0); expCycles += 6; end
                3'd3: begin
                    s = int'(mRegs[rd]) + int'(mRegs[rs]);
                    y = s[7:0]; c = (s > 255); z = (y == 0); expCycles += 8;
                end
                3'd4: begin
                    a = mRegs[rd]; b = mRegs[rs];
                    y = a - b; c = (a < b); z = (y == 0); expCycles += 8;
                end
                3'd5: begin p = lo; expCycles += 3; end
                3'd6: begin if (z) p = lo; expCycles += 3; end
                3'd7: begin expHalt = 1'b1; expCycles += 3; end
                default: expCycles += 3;
            endcase
            if (hi[7:5] inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
                expWr.push_back('{sel: rd, data: y});
                if (rd != 5'd0) mRegs[rd] = y;
            end
            if (expHalt) break;
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic putInstr(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo);
        mem[addr] = hi;
        mem[addr + 8'd1] = lo;
    endtask

    // Runs the loaded program to HALT under a given mem_ready pattern.
    task automatic applyStimulus(input int mode);
        expWr.delete();
        expFe.delete();
        runModel(500);
        readyMode = mode;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        stallCnt = 0;
        haltCycle = -1;
        byteCnt = 0;
        tracking = 1'b1;
        rst = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (mode == 2 && cyc >= 2 && cyc <= 4) begin
                checkOutput("stall mem_rd", {15'd0, mem_rd}, 16'd1);
                checkOutput("stall mem_addr", {8'd0, mem_addr}, 16'h0001);
            end
            if (halted) break;
        end
        repeat (4) @(negedge clk);
        tracking = 1'b0;
        checkOutput("halted", {15'd0, halted}, {15'd0, expHalt});
        checkOutput("halt cycle", haltCycle[15:0], 16'(expCycles + stallCnt));
        checkOutput("fetches left", 16'(expFe.size()), 16'd0);
        checkOutput("writes left", 16'(expWr.size()), 16'd0);
        checkOutput("halt mem_rd", {15'd0, mem_rd}, 16'd0);
        for (int r = 1; r < 8; r++) begin
            checkOutput($sformatf("reg r%0d", r), {8'd0, u_rb.r_regs[r]}, {8'd0, mRegs[r]});
        end
    endtask

    // LDI r1,F0; LDI r2,20; ADD r1,r2 with reset asserted in a chosen cycle.
    task automatic resetMidway(input int atCyc, input logic expWrite,
                               input logic [4:0] expSel, input logic [7:0] expData);
        clearMem();
        putInstr(8'h00, 8'h21, 8'hF0);
        putInstr(8'h02, 8'h22, 8'h20);
        putInstr(8'h04, 8'h61, 8'h02);
        expWr.delete();
        expFe.delete();
        runModel(2);
        expWr.delete();
        expFe.delete();
        readyMode = 0;
        tracking = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 100 && cyc != atCyc; t++) @(negedge clk);
        checkOutput("pre-reset cycle", 16'(cyc), 16'(atCyc));
        checkOutput("pre-reset write", {15'd0, rb_write_reg}, {15'd0, expWrite});
        checkOutput("pre-reset sel", {11'd0, rb_sel}, {11'd0, expSel});
        checkOutput("pre-reset data", {8'd0, rb_data_in}, {8'd0, expData});
        #1 rst = 1'b1;
        #1;
        checkOutput("reset write_reg", {15'd0, rb_write_reg}, 16'd0);
        checkOutput("reset pc", {8'd0, pc}, 16'd0);
        checkOutput("reset mem_rd", {15'd0, mem_rd}, 16'd0);
        checkOutput("reset sel", {11'd0, rb_sel}, 16'd0);
        repeat (3) @(negedge clk);
        checkOutput("aborted target r1", {8'd0, u_rb.r_regs[1]}, {8'd0, mRegs[1]});
    endtask

    initial begin
        logic [7:0] lo;
        logic [2:0] op;
        for (int r = 0; r < 32; r++) mRegs[r] = 8'd0;
        clearMem();
        repeat (2) @(negedge clk);
        checkOutput("rst mem_addr", {8'd0, mem_addr}, 16'd0);
        checkOutput("rst mem_rd", {15'd0, mem_rd}, 16'd0);
        checkOutput("rst rb_sel", {11'd0, rb_sel}, 16'd0);
        checkOutput("rst rb_data_in", {8'd0, rb_data_in}, 16'd0);
        checkOutput("rst rb_write_reg", {15'd0, rb_write_reg}, 16'd0);
        checkOutput("rst pc", {8'd0, pc}, 16'd0);
        checkOutput("rst flags", {14'd0, flag_z, flag_c}, 16'd0);
        checkOutput("rst halted", {15'd0, halted}, 16'd0);

        // Give r1..r7 known contents
        clearMem();
        for (int r = 1; r < 8; r++) putInstr(8'(2 * (r - 1)), 8'h20 | 8'(r), 8'($urandom));
        putInstr(8'd14, 8'hE0, 8'h00);
        applyStimulus(0);

        clearMem();
        putInstr(8'h00, 8'h20, 8'h05);
        putInstr(8'h02, 8'h21, 8'h07);
        putInstr(8'h04, 8'hE0, 8'h00);
        applyStimulus(0);
        checkOutput("r0 reads zero", {8'd0, u_rb.r_regs[0] & 8'h00}, 16'd0);

        clearMem();
        putInstr(8'h00, 8'h21, 8'hF0);
        putInstr(8'h02, 8'h22, 8'h20);
        putInstr(8'h04, 8'h61, 8'h02);
        putInstr(8'h06, 8'hE0, 8'h00);
        applyStimulus(0);

        clearMem();
        putInstr(8'h00, 8'h23, 8'h05);
        putInstr(8'h02, 8'h24, 8'h05);
        putInstr(8'h04, 8'h83, 8'h04);
        putInstr(8'h06, 8'h83, 8'h04);
        putInstr(8'h08, 8'hE0, 8'h00);
        applyStimulus(0);

        clearMem();
        putInstr(8'h00, 8'h21, 8'h00);
        putInstr(8'h02, 8'hC0, 8'h40);
        putInstr(8'h40, 8'h22, 8'h01);
        putInstr(8'h42, 8'hC0, 8'h80);
        putInstr(8'h44, 8'hE0, 8'h00);
        applyStimulus(0);

        // JMP to 0xFF: hi at 0xFF, lo wraps to 0x00, then HALT fetched at 0x01
        clearMem();
        putInstr(8'h00, 8'hA0, 8'hFF);
        mem[8'hFF] = 8'h21;
        applyStimulus(0);

        clearMem();
        putInstr(8'h00, 8'h25, 8'h3C);
        putInstr(8'h02, 8'hE0, 8'h00);
        applyStimulus(2);

        clearMem();
        putInstr(8'h00, 8'h00, 8'h00);
        putInstr(8'h02, 8'h46, 8'h01);
        putInstr(8'h04, 8'h47, 8'h00);
        putInstr(8'h06, 8'hE0, 8'h00);
        applyStimulus(1);

        // Random forward-branching programs so every one reaches HALT
        for (int p = 0; p < 16; p++) begin
            clearMem();
            for (int i = 0; i < 12; i++) begin
                op = 3'($urandom_range(0, 6));
                lo = 8'($urandom);
                if (op == 3'd5 || op == 3'd6) lo = 8'(2 * $urandom_range(i + 1, 12));
                else if (op == 3'd2 || op == 3'd3 || op == 3'd4) lo = {lo[7:5], 5'($urandom_range(0, 7))};
                putInstr(8'(2 * i), {op, 5'($urandom_range(0, 7))}, lo);
            end
            putInstr(8'd24, 8'hE0, 8'h00);
            applyStimulus(p % 2);
        end

        resetMidway(15, 1'b0, 5'd2, 8'h00);
        resetMidway(16, 1'b1, 5'd1, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
